// File: rtl/dii_packet_arbiter.sv
// dii_packet_arbiter: shares one debug-ring DII input slice between N DII
// packet sources. Arbitration is round-robin at packet granularity; a granted
// source owns the output from its first flit through its last flit.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_flat_data      N source flits, source i at [i*WIDTH +: WIDTH]
//   in_flat_first     per-source first-flit markers
//   in_flat_last      per-source last-flit markers
//   in_flat_valid     per-source valid
//   in_flat_ready     per-source ready (only the granted source, when locked)
//   out_data/out_first/out_last/out_valid  arbitrated flit toward the ring
//   out_ready         ring ready
//   grant             one-hot owner of the output, zero when idle
//   busy              high while a packet is locked
module dii_packet_arbiter #(
    parameter int unsigned N     = 2,
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_flat_data,
    input  logic [N-1:0]       in_flat_first,
    input  logic [N-1:0]       in_flat_last,
    input  logic [N-1:0]       in_flat_valid,
    output logic [N-1:0]       in_flat_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_first,
    output logic               out_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       grant,
    output logic               busy
);

    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SUM_W = IDX_W + 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] owner_next;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] rr_ptr_next;
    logic [N-1:0]     grant_next;
    logic             busy_next;

    logic [N-1:0]     eligible;
    logic [2*N-1:0]   elig_dbl;
    logic [N-1:0]     rotated;
    logic             found;
    logic [IDX_W-1:0] offset;
    logic [SUM_W-1:0] win_sum;
    logic [IDX_W-1:0] winner;

    // Round-robin search: rotate the eligible vector so rr_ptr sits at bit 0,
    // take the lowest set bit, then map the offset back to a source index.
    always_comb begin
        eligible = in_flat_valid & in_flat_first;
        elig_dbl = {eligible, eligible} >> rr_ptr;
        rotated  = elig_dbl[N-1:0];
        found    = 1'b0;
        offset   = '0;
        for (int unsigned j = 0; j < N; j++) begin
            if (rotated[j] && !found) begin
                found  = 1'b1;
                offset = IDX_W'(j);
            end
        end
        win_sum = SUM_W'(rr_ptr) + SUM_W'(offset);
        winner  = (win_sum >= SUM_W'(N)) ? IDX_W'(win_sum - SUM_W'(N)) : IDX_W'(win_sum);
    end

    // Next state and the combinational forwarding path of the locked source.
    always_comb begin
        state_next    = state;
        owner_next    = owner;
        rr_ptr_next   = rr_ptr;
        grant_next    = grant;
        busy_next     = busy;
        in_flat_ready = '0;
        out_data      = '0;
        out_first     = 1'b0;
        out_last      = 1'b0;
        out_valid     = 1'b0;

        case (state)
            IDLE: begin
                if (found) begin
                    state_next = LOCKED;
                    owner_next = winner;
                    grant_next = N'(1) << winner;
                    busy_next  = 1'b1;
                end
            end
            LOCKED: begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (owner == IDX_W'(i)) begin
                        out_data         = in_flat_data[i*WIDTH +: WIDTH];
                        out_first        = in_flat_first[i];
                        out_last         = in_flat_last[i];
                        out_valid        = in_flat_valid[i];
                        in_flat_ready[i] = out_ready;
                    end
                end
                // Release only once the last flit has actually transferred.
                if (out_valid && out_ready && out_last) begin
                    state_next  = IDLE;
                    grant_next  = '0;
                    busy_next   = 1'b0;
                    rr_ptr_next = (owner == IDX_W'(N - 1)) ? '0 : owner + IDX_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            grant  <= '0;
            busy   <= 1'b0;
        end else begin
            state  <= state_next;
            owner  <= owner_next;
            rr_ptr <= rr_ptr_next;
            grant  <= grant_next;
            busy   <= busy_next;
        end
    end

endmodule

// File: tb/tb_dii_packet_arbiter.sv
// tb_dii_packet_arbiter: self-checking bench for dii_packet_arbiter (N=4).
// Packets are queued per source; a reference model derives the expected
// output stream (order, flit contents and, for unstalled traffic, cycle of
// each transfer) from the round-robin packet rules.
module tb_dii_packet_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] in_flat_data;
    logic [N-1:0]   in_flat_first;
    logic [N-1:0]   in_flat_last;
    logic [N-1:0]   in_flat_valid;
    logic [N-1:0]   in_flat_ready;
    logic [W-1:0]   out_data;
    logic           out_first;
    logic           out_last;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   grant;
    logic           busy;

    always #5 clk = ~clk;

    dii_packet_arbiter #(.N(N), .WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_flat_data  (in_flat_data),
        .in_flat_first (in_flat_first),
        .in_flat_last  (in_flat_last),
        .in_flat_valid (in_flat_valid),
        .in_flat_ready (in_flat_ready),
        .out_data      (out_data),
        .out_first     (out_first),
        .out_last      (out_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .grant         (grant),
        .busy          (busy)
    );

    typedef struct packed {
        logic [15:0] data;
        logic        first;
        logic        last;
    } flit_t;

    typedef struct {
        flit_t f;
        int    src;
        int    cyc;
    } exp_t;

    flit_t src_q[N][$];
    int    pkt_q[N][$];
    int    seq[N];
    exp_t  exp_q[$];
    int    model_ptr;
    int    n_checks;
    int    n_fail;
    int    busy_cycles;
    int    last_xfer;

    task automatic clear_inputs();
        in_flat_data  = '0;
        in_flat_first = '0;
        in_flat_last  = '0;
        in_flat_valid = '0;
        out_ready     = 1'b0;
    endtask

    task automatic clear_queues();
        for (int s = 0; s < N; s++) begin
            src_q[s].delete();
            pkt_q[s].delete();
        end
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
        clear_queues();
    endtask

    // Flit data is {source, per-source sequence number}.
    task automatic add_packet(input int s, input int len);
        flit_t f;
        for (int j = 0; j < len; j++) begin
            f.data  = {4'(s), 12'(seq[s])};
            f.first = (j == 0);
            f.last  = (j == len - 1);
            seq[s]++;
            src_q[s].push_back(f);
        end
        pkt_q[s].push_back(len);
    endtask

    // Reference: starting at the round-robin pointer, the next packet comes
    // from the first source with pending packets; each packet costs one
    // arbitration cycle plus one cycle per flit.
    task automatic build_expected();
        int   idx[N];
        int   base;
        int   ptr;
        int   len;
        int   s;
        bit   found;
        exp_t e;
        for (int k = 0; k < N; k++) idx[k] = 0;
        base  = 0;
        ptr   = model_ptr;
        found = 1'b1;
        while (found) begin
            found = 1'b0;
            for (int k = 0; k < N && !found; k++) begin
                s = (ptr + k) % N;
                if (pkt_q[s].size() > 0) begin
                    len = pkt_q[s].pop_front();
                    for (int j = 0; j < len; j++) begin
                        e.f   = src_q[s][idx[s] + j];
                        e.src = s;
                        e.cyc = base + 1 + j;
                        exp_q.push_back(e);
                    end
                    idx[s] += len;
                    base   += len + 1;
                    ptr     = (s + 1) % N;
                    found   = 1'b1;
                end
            end
        end
        model_ptr = ptr;
    endtask

    // Present queued packets and check every output transfer against the model.
    // rnd=1 adds random out_ready stalls and mid-packet valid gaps.
    task automatic run_traffic(input bit rnd);
        int    cyc;
        bit    pending;
        flit_t h;
        exp_t  e;
        cyc         = 0;
        busy_cycles = 0;
        last_xfer   = -1;
        build_expected();
        pending = 1'b1;
        while (pending && cyc < 2000) begin
            @(negedge clk);
            for (int s = 0; s < N; s++) begin
                if (src_q[s].size() > 0) begin
                    h = src_q[s][0];
                    in_flat_data[s*W +: W] = h.data;
                    in_flat_first[s]       = h.first;
                    in_flat_last[s]        = h.last;
                    in_flat_valid[s]       = h.first ? 1'b1 : (rnd ? ($urandom_range(3) != 0) : 1'b1);
                end else begin
                    in_flat_data[s*W +: W] = 16'($urandom);
                    in_flat_first[s]       = 1'b0;
                    in_flat_last[s]        = 1'b0;
                    in_flat_valid[s]       = 1'b0;
                end
            end
            out_ready = rnd ? ($urandom_range(2) != 0) : 1'b1;
            #1;
            if (busy) busy_cycles++;
            n_checks++;
            if ((in_flat_ready & ~grant) !== '0) begin
                n_fail++;
                $display("FAIL ready_outside_grant: ready=%b grant=%b, required no ready bit outside grant", in_flat_ready, grant);
            end
            if (cyc == 0) begin
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL arb_cycle_valid: out_valid=%b, required 0 in the arbitration cycle", out_valid);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_xfer: data=%h transferred, required no transfer", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_data, out_first, out_last} !== e.f) begin
                        n_fail++;
                        $display("FAIL flit: got data=%h first=%b last=%b, required data=%h first=%b last=%b",
                                 out_data, out_first, out_last, e.f.data, e.f.first, e.f.last);
                    end
                    n_checks++;
                    if (grant !== (N'(1) << e.src) || in_flat_ready !== (N'(1) << e.src)) begin
                        n_fail++;
                        $display("FAIL xfer_owner: grant=%b ready=%b, required source %0d", grant, in_flat_ready, e.src);
                    end
                    if (!rnd) begin
                        n_checks++;
                        if (cyc != e.cyc) begin
                            n_fail++;
                            $display("FAIL xfer_cycle: flit %h at cycle %0d, required cycle %0d", e.f.data, cyc, e.cyc);
                        end
                    end
                    last_xfer = cyc;
                end
            end
            for (int s = 0; s < N; s++) begin
                if (in_flat_valid[s] && in_flat_ready[s]) src_q[s].delete(0);
            end
            pending = (exp_q.size() > 0);
            cyc++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL traffic_timeout: %0d flits outstanding after %0d cycles, required 0", exp_q.size(), cyc);
        end
        clear_queues();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic test_reset();
        in_flat_valid = '1;
        in_flat_first = '1;
        in_flat_data  = '1;
        out_ready     = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (grant !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: grant=%b busy=%b, required 0/0", grant, busy);
        end
        n_checks++;
        if (out_valid !== 1'b0 || in_flat_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_handshake: out_valid=%b ready=%b, required 0/0", out_valid, in_flat_ready);
        end
        n_checks++;
        if ({out_data, out_first, out_last} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: data=%h first=%b last=%b, required all 0", out_data, out_first, out_last);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        model_ptr = 0;
    endtask

    task automatic test_single_source();
        add_packet(1, 3);
        run_traffic(1'b0);
        n_checks++;
        if (busy_cycles != 3 || last_xfer != 3) begin
            n_fail++;
            $display("FAIL single_source_timing: busy cycles=%0d last xfer=%0d, required 3/3", busy_cycles, last_xfer);
        end
    endtask

    task automatic test_rr_pointer();
        add_packet(0, 1);
        add_packet(2, 1);
        run_traffic(1'b0);
    endtask

    task automatic test_simultaneous();
        do_reset();
        add_packet(0, 2);
        add_packet(1, 2);
        run_traffic(1'b0);
        n_checks++;
        if (last_xfer != 5) begin
            n_fail++;
            $display("FAIL simultaneous_span: last xfer cycle=%0d, required 5", last_xfer);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < N; s++) add_packet(s, 1);
        run_traffic(1'b0);
        n_checks++;
        if (last_xfer != 15) begin
            n_fail++;
            $display("FAIL fairness_rate: last xfer cycle=%0d, required 15", last_xfer);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clk);
        in_flat_data[0 +: W] = 16'hA000;
        in_flat_first[0]     = 1'b1;
        in_flat_valid[0]     = 1'b1;
        out_ready            = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_arb: out_valid=%b, required 0", out_valid);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (grant !== 4'b0001 || out_data !== 16'hA000 || in_flat_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL bp_first: grant=%b data=%h ready=%b, required 0001/a000/0001", grant, out_data, in_flat_ready);
        end
        @(negedge clk);
        in_flat_data[0 +: W] = 16'hA001;
        in_flat_first[0]     = 1'b0;
        in_flat_data[W +: W] = 16'hB000;
        in_flat_first[1]     = 1'b1;
        in_flat_last[1]      = 1'b1;
        in_flat_valid[1]     = 1'b1;
        out_ready            = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            n_checks++;
            if (grant !== 4'b0001 || out_data !== 16'hA001 || in_flat_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_stall: cycle %0d grant=%b data=%h ready=%b, required 0001/a001/0000", i, grant, out_data, in_flat_ready);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_flat_ready !== 4'b0001 || out_data !== 16'hA001) begin
            n_fail++;
            $display("FAIL bp_resume: ready=%b data=%h, required 0001/a001", in_flat_ready, out_data);
        end
        @(negedge clk);
        in_flat_data[0 +: W] = 16'hA002;
        in_flat_last[0]      = 1'b1;
        #1;
        n_checks++;
        if (grant !== 4'b0001 || out_last !== 1'b1 || in_flat_ready[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_last: grant=%b last=%b ready1=%b, required 0001/1/0", grant, out_last, in_flat_ready[1]);
        end
        @(negedge clk);
        in_flat_valid[0] = 1'b0;
        #1;
        n_checks++;
        if (grant !== '0 || out_valid !== 1'b0 || in_flat_ready !== '0) begin
            n_fail++;
            $display("FAIL bp_release: grant=%b valid=%b ready=%b, required 0/0/0", grant, out_valid, in_flat_ready);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (grant !== 4'b0010 || out_data !== 16'hB000 || in_flat_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_next_source: grant=%b data=%h ready=%b, required 0010/b000/0010", grant, out_data, in_flat_ready);
        end
        @(posedge clk);
        #1;
        clear_inputs();
        model_ptr = 2;
    endtask

    task automatic test_non_first();
        do_reset();
        @(negedge clk);
        in_flat_data[0 +: W] = 16'hC000;
        in_flat_valid[0]     = 1'b1;
        out_ready            = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (grant !== '0 || in_flat_ready !== '0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL non_first_held: cycle %0d grant=%b ready=%b busy=%b, required 0/0/0", i, grant, in_flat_ready, busy);
            end
            @(negedge clk);
        end
        in_flat_first[0] = 1'b1;
        in_flat_last[0]  = 1'b1;
        #1;
        n_checks++;
        if (grant !== '0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL non_first_arb: grant=%b valid=%b, required 0/0", grant, out_valid);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (grant !== 4'b0001 || out_data !== 16'hC000 || out_first !== 1'b1) begin
            n_fail++;
            $display("FAIL non_first_grant: grant=%b data=%h first=%b, required 0001/c000/1", grant, out_data, out_first);
        end
        @(posedge clk);
        #1;
        clear_inputs();
        model_ptr = 1;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_flat_data[2*W +: W] = 16'hD000;
        in_flat_first[2]       = 1'b1;
        in_flat_valid[2]       = 1'b1;
        out_ready              = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (grant !== 4'b0100 || out_data !== 16'hD000) begin
            n_fail++;
            $display("FAIL mid_grant: grant=%b data=%h, required 0100/d000", grant, out_data);
        end
        @(negedge clk);
        in_flat_data[2*W +: W] = 16'hD001;
        in_flat_first[2]       = 1'b0;
        @(posedge clk);
        #2;
        in_flat_data[2*W +: W] = 16'hD002;
        rst = 1'b1;
        #1;
        n_checks++;
        if (grant !== '0 || busy !== 1'b0 || out_valid !== 1'b0 || in_flat_ready !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_async: grant=%b busy=%b valid=%b ready=%b, required all 0", grant, busy, out_valid, in_flat_ready);
        end
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
        clear_queues();
        add_packet(3, 1);
        add_packet(0, 1);
        run_traffic(1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            for (int s = 0; s < N; s++) begin
                int np;
                np = int'($urandom_range(3));
                for (int p = 0; p < np; p++) add_packet(s, int'($urandom_range(5, 1)));
            end
            run_traffic(1'b1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        model_ptr = 0;
        for (int s = 0; s < N; s++) seq[s] = 0;
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_source();
        test_rr_pointer();
        test_simultaneous();
        test_fairness();
        test_backpressure();
        test_non_first();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
